// File: rtl/bcd2bin16_pkg.sv
// rtl/bcd2bin16_pkg.sv - shared state encodings and BCD constants for the BCD/binary converters
package bcd2bin16_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam int               BCD_DIGIT_W  = 4;
  localparam logic [3:0]       BCD_MAX      = 4'd9;
  localparam logic [3:0]       DABBLE_THRSH = 4'd8;
  localparam logic [3:0]       DABBLE_ADJ   = 4'd3;

  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd2bin16_if.sv
// rtl/bcd2bin16_if.sv - request/result bundle between a decimal source and the converter
interface bcd2bin16_if #(
  parameter int NDIG = 5,
  parameter int BW   = 16
);

  logic                en;
  logic [4*NDIG-1:0]   bcd;
  logic [BW-1:0]       bin;
  logic                ovf;
  logic                err;
  logic                busy;
  logic                fin;

  modport master (
    output en, bcd,
    input  bin, ovf, err, busy, fin
  );

  modport slave (
    input  en, bcd,
    output bin, ovf, err, busy, fin
  );

endinterface

// File: rtl/bcd2bin16_dabble_sub3.sv
// rtl/bcd2bin16_dabble_sub3.sv - reverse double-dabble digit correction (d>=8 ? d-3 : d)
module bcd_dabble_sub3
  import bcd2bin16_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  // Wraps mod 16 by construction; only reachable for d>=8 so no borrow is possible.
  assign q = (d >= DABBLE_THRSH) ? (d - DABBLE_ADJ) : d;

endmodule

// File: rtl/bcd2bin16.sv
// rtl/bcd2bin16.sv - sequential BCD-to-binary converter using reverse double-dabble
module bcd2bin16
  import bcd2bin16_pkg::*;
#(
  parameter int NDIG = 5,
  parameter int BW   = 16
)(
  input  logic         CLK,
  input  logic         RST,
  bcd2bin16_if.slave   bus
);

  localparam int DW    = BCD_DIGIT_W * NDIG;
  localparam int ITER  = BW + 1;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int SW    = DW + BW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [DW-1:0]      bcd_q;
  logic [BW:0]        acc_q;
  logic               err_q;

  logic [BW-1:0]      bin_q;
  logic               ovf_q;
  logic               err_out_q;

  logic               in_err;
  logic [SW-1:0]      scratch_sh;
  logic [DW-1:0]      sh_bcd;
  logic [DW-1:0]      corr_bcd;
  logic [BW:0]        sh_acc;
  logic               last_iter;
  logic               ovf_d;

  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      in_err = in_err | digit_invalid(bus.bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
    end
  end

  // One combined right shift across the digit field and the binary accumulator.
  assign scratch_sh = {bcd_q, acc_q} >> 1;
  assign sh_bcd     = scratch_sh[SW-1 -: DW];
  assign sh_acc     = scratch_sh[BW:0];

  for (genvar g = 0; g < NDIG; g++) begin : g_sub3
    bcd_dabble_sub3 u_sub3 (
      .d (sh_bcd[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .q (corr_bcd[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  assign last_iter = (state_q == S_BUSY) && (cnt_q == CNT_LAST);

  // Anything left in the digit field after ITER shifts means the value exceeded BW+1 bits.
  assign ovf_d = ~err_q & (sh_acc[BW] | (|corr_bcd));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.en) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == CNT_LAST) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      bcd_q <= '0;
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (bus.en) begin
            bcd_q <= bus.bcd;
            acc_q <= '0;
            err_q <= in_err;
          end
        end
        S_BUSY: begin
          bcd_q <= corr_bcd;
          acc_q <= sh_acc;
          cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  // Results are taken from the post-shift values so the final iteration is included.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bin_q     <= '0;
      ovf_q     <= 1'b0;
      err_out_q <= 1'b0;
    end else if (last_iter) begin
      bin_q     <= err_q ? '0 : sh_acc[BW-1:0];
      ovf_q     <= ovf_d;
      err_out_q <= err_q;
    end
  end

  assign bus.bin  = bin_q;
  assign bus.ovf  = ovf_q;
  assign bus.err  = err_out_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.fin  = (state_q == S_FIN);

endmodule

// File: tb/tb_bcd2bin16.sv
// tb/tb_bcd2bin16.sv - directed self-checking bench for bcd2bin16
module tb_bcd2bin16;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  bcd2bin16_if #(.NDIG(5), .BW(16)) bus ();

  bcd2bin16 #(.NDIG(5), .BW(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Raise en after edge k, drop it after edge k+1; lat = n of the first cycle (from edge k) with fin.
  task automatic run_conv(input logic [19:0] v, output int lat, output int busy_cnt,
                          output logic [15:0] b, output logic o, output logic e);
    lat = -1;
    busy_cnt = 0;
    b = '0; o = 1'b0; e = 1'b0;
    @(posedge CLK);
    #1;
    bus.bcd = v;
    bus.en  = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK);
      if (n == 1) begin
        #1;
        bus.en = 1'b0;
      end
      @(negedge CLK);
      if (bus.busy) busy_cnt++;
      if (bus.fin) begin
        lat = n;
        b = bus.bin; o = bus.ovf; e = bus.err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    bus.en = 1'b0;
    bus.bcd = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({bus.busy, bus.fin, bus.ovf, bus.err} !== 4'b0000 || bus.bin !== 16'h0000) begin
      failures++;
      $display("FAIL reset: busy=%b fin=%b ovf=%b err=%b bin=%h required all 0",
               bus.busy, bus.fin, bus.ovf, bus.err, bus.bin);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_basic;
    int lat, bc;
    logic [15:0] b;
    logic o, e;
    run_conv(20'h12345, lat, bc, b, o, e);
    checks++;
    if (lat !== 18) begin failures++; $display("FAIL basic_latency: got %0d required 18", lat); end
    checks++;
    if (bc !== 18) begin failures++; $display("FAIL basic_busy_cycles: got %0d required 18", bc); end
    checks++;
    if ({b, o, e} !== {16'h3039, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_result: bin=%h ovf=%b err=%b required 3039 0 0", b, o, e);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (bus.fin !== 1'b0 || bus.busy !== 1'b0 || bus.bin !== 16'h3039) begin
      failures++;
      $display("FAIL basic_hold: fin=%b busy=%b bin=%h required 0 0 3039", bus.fin, bus.busy, bus.bin);
    end
  endtask

  task automatic test_boundaries;
    logic [19:0] vin [4];
    logic [15:0] vbin [4];
    logic        vovf [4];
    int lat, bc;
    logic [15:0] b;
    logic o, e;
    vin[0] = 20'h65535; vbin[0] = 16'hFFFF; vovf[0] = 1'b0;
    vin[1] = 20'h65536; vbin[1] = 16'h0000; vovf[1] = 1'b1;
    vin[2] = 20'h99999; vbin[2] = 16'h869F; vovf[2] = 1'b1;
    vin[3] = 20'h00000; vbin[3] = 16'h0000; vovf[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_conv(vin[i], lat, bc, b, o, e);
      checks++;
      if (lat !== 18 || b !== vbin[i] || o !== vovf[i] || e !== 1'b0) begin
        failures++;
        $display("FAIL boundary_%h: lat=%0d bin=%h ovf=%b err=%b required 18 %h %b 0",
                 vin[i], lat, b, o, e, vbin[i], vovf[i]);
      end
    end
  endtask

  task automatic test_bad_digit;
    int lat, bc;
    logic [15:0] b;
    logic o, e;
    run_conv(20'h000A0, lat, bc, b, o, e);
    checks++;
    if (lat !== 18 || b !== 16'h0000 || o !== 1'b0 || e !== 1'b1) begin
      failures++;
      $display("FAIL bad_digit: lat=%0d bin=%h ovf=%b err=%b required 18 0000 0 1", lat, b, o, e);
    end
    run_conv(20'h00010, lat, bc, b, o, e);
    checks++;
    if (b !== 16'h000A || e !== 1'b0) begin
      failures++;
      $display("FAIL err_clears: bin=%h err=%b required 000a 0", b, e);
    end
  endtask

  task automatic test_back_to_back;
    int fin_cnt, fin1, fin2;
    logic [15:0] bin1, bin2;
    fin_cnt = 0; fin1 = -1; fin2 = -1;
    bin1 = '0; bin2 = '0;
    @(posedge CLK);
    #1;
    bus.bcd = 20'h00100;
    bus.en  = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK);
      #1;
      if (n == 5)  bus.bcd = 20'h00777;
      if (n == 20) bus.en  = 1'b0;
      if (n == 25) bus.bcd = 20'h99999;
      @(negedge CLK);
      if (bus.fin) begin
        fin_cnt++;
        if (fin_cnt == 1) begin fin1 = n; bin1 = bus.bin; end
        if (fin_cnt == 2) begin fin2 = n; bin2 = bus.bin; end
      end
    end
    checks++;
    if (fin_cnt !== 2) begin failures++; $display("FAIL b2b_fin_count: got %0d required 2", fin_cnt); end
    checks++;
    if (fin1 !== 18 || bin1 !== 16'h0064) begin
      failures++;
      $display("FAIL b2b_first: at=%0d bin=%h required 18 0064", fin1, bin1);
    end
    checks++;
    if (fin2 - fin1 !== 19 || bin2 !== 16'h0309) begin
      failures++;
      $display("FAIL b2b_second: gap=%0d bin=%h required 19 0309", fin2 - fin1, bin2);
    end
  endtask

  task automatic test_reset_mid;
    int fin_cnt, lat, bc;
    logic [15:0] b;
    logic o, e;
    fin_cnt = 0;
    @(posedge CLK);
    #1;
    bus.bcd = 20'h54321;
    bus.en  = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge CLK);
      #1;
      if (n == 1) bus.en = 1'b0;
      if (n == 8) RST = 1'b1;
      if (n == 9) RST = 1'b0;
      @(negedge CLK);
      if (bus.fin) fin_cnt++;
      if (n == 9) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.bin !== 16'h0000) begin
          failures++;
          $display("FAIL reset_mid_state: busy=%b bin=%h required 0 0000", bus.busy, bus.bin);
        end
      end
    end
    checks++;
    if (fin_cnt !== 0) begin failures++; $display("FAIL reset_mid_fin: got %0d pulses required 0", fin_cnt); end
    run_conv(20'h00042, lat, bc, b, o, e);
    checks++;
    if (lat !== 18 || b !== 16'h002A || o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_fresh: lat=%0d bin=%h ovf=%b required 18 002a 0", lat, b, o);
    end
  endtask

  task automatic test_random;
    int v, lat, bc;
    logic [15:0] b, exp_b;
    logic o, e, exp_o;
    for (int i = 0; i < 10; i++) begin
      v = int'($urandom_range(99999, 0));
      exp_b = 16'(v);
      exp_o = (v > 65535);
      run_conv(to_bcd(v), lat, bc, b, o, e);
      checks++;
      if (lat !== 18 || b !== exp_b || o !== exp_o || e !== 1'b0) begin
        failures++;
        $display("FAIL random_%0d: lat=%0d bin=%h ovf=%b err=%b required 18 %h %b 0",
                 v, lat, b, o, e, exp_b, exp_o);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_basic;
    test_boundaries;
    test_bad_digit;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
